// File: rtl/pipe_controller.sv
// Pipeline control registers (D->E->M->W) for a CPU datapath, with a
// multi-cycle execute sequencer, branch condition check and the architectural flags.
module pipe_controller #(
  parameter int NWP    = 2,
  parameter int ALUW   = 5,
  parameter int MULCYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [NWP-1:0]  RegWriteD,
  input  logic            ALUSrcD,
  input  logic            PCSD,
  input  logic            LoadMemD,
  input  logic            MultiCycD,
  input  logic [ALUW-1:0] ALUControlD,
  input  logic [1:0]      FlagWD,
  input  logic [2:0]      BranchTypeD,
  input  logic [3:0]      ALUFlags,
  output logic            ALUSrcE,
  output logic            LoadMemE,
  output logic [ALUW-1:0] ALUControlE,
  output logic [NWP-1:0]  RegWriteE,
  output logic [NWP-1:0]  RegWriteM,
  output logic [NWP-1:0]  RegWriteW,
  output logic            LoadMemM,
  output logic            PCSrcE,
  output logic            BusyE,
  output logic [3:0]      FlagsQ
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic            valid;
    logic [NWP-1:0]  reg_write;
    logic            alu_src;
    logic            pcs;
    logic            load_mem;
    logic            multi_cyc;
    logic [ALUW-1:0] alu_control;
    logic [1:0]      flag_w;
    logic [2:0]      branch_type;
  } e_ctrl_t;

  localparam logic [3:0] CNT_LOAD = 4'(MULCYC - 2);

  e_ctrl_t         d_ctrl, e_ctrl;
  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            busy;
  logic            cond;
  logic            advance;
  logic [NWP-1:0]  reg_write_m, reg_write_w;
  logic            load_mem_m;
  logic [3:0]      flags_q;

  always_comb begin
    d_ctrl             = '0;
    d_ctrl.valid       = 1'b1;
    d_ctrl.reg_write   = RegWriteD;
    d_ctrl.alu_src     = ALUSrcD;
    d_ctrl.pcs         = PCSD;
    d_ctrl.load_mem    = LoadMemD;
    d_ctrl.multi_cyc   = MultiCycD;
    d_ctrl.alu_control = ALUControlD;
    d_ctrl.flag_w      = FlagWD;
    d_ctrl.branch_type = BranchTypeD;
  end

  // Multi-cycle sequencer: the IDLE cycle plus MULCYC-1 BUSY cycles give MULCYC cycles in E.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_n = state;
    cnt_n   = cnt;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (e_ctrl.valid && e_ctrl.multi_cyc) begin
          busy    = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          busy  = 1'b1;
          cnt_n = cnt - 4'd1;
        end else if (!StallE || FlushE) begin
          // A stall on the final cycle keeps the instruction in E; re-entering IDLE would restart it.
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    unique case (e_ctrl.branch_type)
      3'b000: cond = 1'b0;
      3'b001: cond = 1'b1;
      3'b010: cond = flags_q[2];
      3'b011: cond = !flags_q[2];
      3'b100: cond = flags_q[3] ^ flags_q[0];
      3'b101: cond = !(flags_q[3] ^ flags_q[0]);
      3'b110: cond = flags_q[1];
      3'b111: cond = !flags_q[1];
      default: cond = 1'b0;
    endcase
  end

  assign advance = !StallE && !busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      e_ctrl      <= '0;
      reg_write_m <= '0;
      load_mem_m  <= 1'b0;
      reg_write_w <= '0;
      flags_q     <= 4'b0000;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;

      if (busy)        e_ctrl <= e_ctrl;
      else if (FlushE) e_ctrl <= '0;
      else if (StallE) e_ctrl <= e_ctrl;
      else             e_ctrl <= d_ctrl;

      if (advance) begin
        reg_write_m <= e_ctrl.reg_write;
        load_mem_m  <= e_ctrl.load_mem;
      end else begin
        reg_write_m <= '0;
        load_mem_m  <= 1'b0;
      end
      reg_write_w <= reg_write_m;

      if (e_ctrl.valid && advance) begin
        if (e_ctrl.flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (e_ctrl.flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign ALUSrcE     = e_ctrl.alu_src;
  assign LoadMemE    = e_ctrl.load_mem;
  assign ALUControlE = e_ctrl.alu_control;
  assign RegWriteE   = e_ctrl.reg_write;
  assign RegWriteM   = reg_write_m;
  assign RegWriteW   = reg_write_w;
  assign LoadMemM    = load_mem_m;
  assign BusyE       = busy;
  assign PCSrcE      = e_ctrl.valid && e_ctrl.pcs && cond && advance;
  assign FlagsQ      = flags_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: a per-cycle vector table for the single-cycle
// pipeline, then hand-written multi-cycle and reset-abort sequences.
module tb_pipe_controller;

  localparam int NWP    = 2;
  localparam int ALUW   = 5;
  localparam int MULCYC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_e, flush_e;
  logic [NWP-1:0]  reg_write_d;
  logic            alu_src_d, pcs_d, load_mem_d, multi_cyc_d;
  logic [ALUW-1:0] alu_control_d;
  logic [1:0]      flag_w_d;
  logic [2:0]      branch_type_d;
  logic [3:0]      alu_flags;
  logic            alu_src_e, load_mem_e, load_mem_m, pc_src_e, busy_e;
  logic [ALUW-1:0] alu_control_e;
  logic [NWP-1:0]  reg_write_e, reg_write_m, reg_write_w;
  logic [3:0]      flags_q;

  pipe_controller #(.NWP(NWP), .ALUW(ALUW), .MULCYC(MULCYC)) dut (
    .clk(clk), .reset(reset), .StallE(stall_e), .FlushE(flush_e),
    .RegWriteD(reg_write_d), .ALUSrcD(alu_src_d), .PCSD(pcs_d), .LoadMemD(load_mem_d),
    .MultiCycD(multi_cyc_d), .ALUControlD(alu_control_d), .FlagWD(flag_w_d),
    .BranchTypeD(branch_type_d), .ALUFlags(alu_flags),
    .ALUSrcE(alu_src_e), .LoadMemE(load_mem_e), .ALUControlE(alu_control_e),
    .RegWriteE(reg_write_e), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .LoadMemM(load_mem_m), .PCSrcE(pc_src_e), .BusyE(busy_e), .FlagsQ(flags_q)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       stall, flush;
    logic [1:0] rw;
    logic       pcs, load, multi;
    logic [4:0] ac;
    logic [1:0] fw;
    logic [2:0] bt;
    logic [3:0] af;
    logic [1:0] x_rw_e, x_rw_m, x_rw_w;
    logic       x_pcsrc, x_busy;
    logic [3:0] x_flags;
    logic [4:0] x_ac_e;
    logic       x_load_m;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  logic       mc_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] mc_rw_m [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
  logic [4:0] mc_ac_e [5] = '{5'h07, 5'h07, 5'h07, 5'h07, 5'h09};
  logic [3:0] mc_flags[5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1011};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [1:0] rw, input logic pcs, input logic load, input logic multi,
                       input logic [4:0] ac, input logic [1:0] fw, input logic [2:0] bt);
    reg_write_d   = rw;
    alu_src_d     = 1'b0;
    pcs_d         = pcs;
    load_mem_d    = load;
    multi_cyc_d   = multi;
    alu_control_d = ac;
    flag_w_d      = fw;
    branch_type_d = bt;
  endtask

  initial begin
    //          st fl rw     pcs ld mc ac     fw     bt      af     | rw_e   rw_m   rw_w   pc bsy flags  ac_e   ldm
    vecs[0]  = '{0, 0, 2'b11, 0, 0, 0, 5'h03, 2'b00, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 5'h00, 0};
    vecs[1]  = '{0, 0, 2'b00, 0, 0, 0, 5'h00, 2'b00, 3'b000, 4'h0, 2'b11, 2'b00, 2'b00, 0, 0, 4'h0, 5'h03, 0};
    vecs[2]  = '{0, 0, 2'b00, 0, 0, 0, 5'h00, 2'b00, 3'b000, 4'h0, 2'b00, 2'b11, 2'b00, 0, 0, 4'h0, 5'h00, 0};
    vecs[3]  = '{0, 0, 2'b00, 0, 0, 0, 5'h0A, 2'b10, 3'b000, 4'h0, 2'b00, 2'b00, 2'b11, 0, 0, 4'h0, 5'h00, 0};
    vecs[4]  = '{0, 0, 2'b00, 1, 0, 0, 5'h00, 2'b00, 3'b010, 4'h4, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 5'h0A, 0};
    vecs[5]  = '{0, 0, 2'b00, 0, 0, 0, 5'h00, 2'b00, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, 1, 0, 4'h4, 5'h00, 0};
    vecs[6]  = '{0, 0, 2'b00, 0, 0, 0, 5'h0A, 2'b10, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h4, 5'h00, 0};
    vecs[7]  = '{0, 0, 2'b00, 1, 0, 0, 5'h00, 2'b00, 3'b010, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h4, 5'h0A, 0};
    vecs[8]  = '{0, 0, 2'b00, 1, 0, 0, 5'h11, 2'b00, 3'b011, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 5'h00, 0};
    vecs[9]  = '{1, 1, 2'b00, 0, 0, 0, 5'h00, 2'b00, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 5'h11, 0};
    vecs[10] = '{0, 0, 2'b01, 0, 1, 0, 5'h05, 2'b01, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h0, 5'h00, 0};
    vecs[11] = '{1, 0, 2'b10, 0, 0, 0, 5'h06, 2'b00, 3'b000, 4'h3, 2'b01, 2'b00, 2'b00, 0, 0, 4'h0, 5'h05, 0};
    vecs[12] = '{1, 0, 2'b10, 0, 0, 0, 5'h06, 2'b00, 3'b000, 4'h3, 2'b01, 2'b00, 2'b00, 0, 0, 4'h0, 5'h05, 0};
    vecs[13] = '{0, 0, 2'b10, 0, 0, 0, 5'h06, 2'b00, 3'b000, 4'h3, 2'b01, 2'b00, 2'b00, 0, 0, 4'h0, 5'h05, 0};
    vecs[14] = '{0, 0, 2'b00, 1, 0, 0, 5'h00, 2'b00, 3'b110, 4'hF, 2'b10, 2'b01, 2'b00, 0, 0, 4'h3, 5'h06, 1};
    vecs[15] = '{0, 0, 2'b00, 1, 0, 0, 5'h00, 2'b00, 3'b100, 4'h0, 2'b00, 2'b10, 2'b01, 1, 0, 4'h3, 5'h00, 0};
    vecs[16] = '{0, 0, 2'b00, 1, 0, 0, 5'h00, 2'b00, 3'b101, 4'h0, 2'b00, 2'b00, 2'b10, 1, 0, 4'h3, 5'h00, 0};
    vecs[17] = '{0, 0, 2'b00, 1, 0, 0, 5'h00, 2'b00, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h3, 5'h00, 0};
    vecs[18] = '{0, 0, 2'b00, 0, 0, 0, 5'h00, 2'b00, 3'b000, 4'h0, 2'b00, 2'b00, 2'b00, 0, 0, 4'h3, 5'h00, 0};

    // Reset held with busy-looking D inputs: every output must stay 0.
    reset     = 1'b1;
    stall_e   = 1'b0;
    flush_e   = 1'b0;
    alu_flags = 4'hF;
    set_d(2'b11, 1'b1, 1'b1, 1'b1, 5'h1F, 2'b11, 3'b001);
    tick();
    tick();
    check("reset RegWriteE", 32'(reg_write_e), 32'h0);
    check("reset RegWriteM", 32'(reg_write_m), 32'h0);
    check("reset RegWriteW", 32'(reg_write_w), 32'h0);
    check("reset ALUControlE", 32'(alu_control_e), 32'h0);
    check("reset ALUSrcE", 32'(alu_src_e), 32'h0);
    check("reset LoadMemE", 32'(load_mem_e), 32'h0);
    check("reset LoadMemM", 32'(load_mem_m), 32'h0);
    check("reset PCSrcE", 32'(pc_src_e), 32'h0);
    check("reset BusyE", 32'(busy_e), 32'h0);
    check("reset FlagsQ", 32'(flags_q), 32'h0);

    set_d(2'b00, 1'b0, 1'b0, 1'b0, 5'h00, 2'b00, 3'b000);
    alu_flags = 4'h0;
    reset     = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall_e   = vecs[i].stall;
      flush_e   = vecs[i].flush;
      alu_flags = vecs[i].af;
      set_d(vecs[i].rw, vecs[i].pcs, vecs[i].load, vecs[i].multi, vecs[i].ac, vecs[i].fw, vecs[i].bt);
      #1;
      check($sformatf("v%0d RegWriteE", i), 32'(reg_write_e), 32'(vecs[i].x_rw_e));
      check($sformatf("v%0d RegWriteM", i), 32'(reg_write_m), 32'(vecs[i].x_rw_m));
      check($sformatf("v%0d RegWriteW", i), 32'(reg_write_w), 32'(vecs[i].x_rw_w));
      check($sformatf("v%0d PCSrcE", i), 32'(pc_src_e), 32'(vecs[i].x_pcsrc));
      check($sformatf("v%0d BusyE", i), 32'(busy_e), 32'(vecs[i].x_busy));
      check($sformatf("v%0d FlagsQ", i), 32'(flags_q), 32'(vecs[i].x_flags));
      check($sformatf("v%0d ALUControlE", i), 32'(alu_control_e), 32'(vecs[i].x_ac_e));
      check($sformatf("v%0d LoadMemM", i), 32'(load_mem_m), 32'(vecs[i].x_load_m));
      tick();
    end
    stall_e = 1'b0;
    flush_e = 1'b0;

    // Multi-cycle op (sets N,Z on its last E cycle) followed by a plain op; flush in cycle 1 is ignored.
    set_d(2'b11, 1'b0, 1'b0, 1'b1, 5'h07, 2'b10, 3'b000);
    alu_flags = 4'b1000;
    tick();
    set_d(2'b01, 1'b0, 1'b0, 1'b0, 5'h09, 2'b00, 3'b000);
    for (int k = 0; k < 5; k++) begin
      flush_e = (k == 1);
      #1;
      check($sformatf("mc%0d BusyE", k), 32'(busy_e), 32'(mc_busy[k]));
      check($sformatf("mc%0d RegWriteM", k), 32'(reg_write_m), 32'(mc_rw_m[k]));
      check($sformatf("mc%0d ALUControlE", k), 32'(alu_control_e), 32'(mc_ac_e[k]));
      check($sformatf("mc%0d FlagsQ", k), 32'(flags_q), 32'(mc_flags[k]));
      if (k == 4) set_d(2'b11, 1'b0, 1'b0, 1'b1, 5'h0C, 2'b11, 3'b000);
      tick();
    end
    flush_e = 1'b0;

    // Second multi-cycle op, aborted by reset while BUSY.
    set_d(2'b00, 1'b0, 1'b0, 1'b0, 5'h00, 2'b00, 3'b000);
    alu_flags = 4'hF;
    #1;
    check("abort busy first", 32'(busy_e), 32'h1);
    check("abort ALUControlE", 32'(alu_control_e), 32'h0C);
    tick();
    check("abort busy second", 32'(busy_e), 32'h1);
    reset = 1'b1;
    #1;
    check("abort in-reset BusyE", 32'(busy_e), 32'h0);
    check("abort in-reset FlagsQ", 32'(flags_q), 32'h0);
    check("abort in-reset RegWriteW", 32'(reg_write_w), 32'h0);
    check("abort in-reset RegWriteE", 32'(reg_write_e), 32'h0);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("post%0d BusyE", c), 32'(busy_e), 32'h0);
      check($sformatf("post%0d RegWriteW", c), 32'(reg_write_w), 32'h0);
      check($sformatf("post%0d FlagsQ", c), 32'(flags_q), 32'h0);
    end
    set_d(2'b10, 1'b0, 1'b0, 1'b0, 5'h02, 2'b00, 3'b000);
    tick();
    set_d(2'b00, 1'b0, 1'b0, 1'b0, 5'h00, 2'b00, 3'b000);
    check("new RegWriteE", 32'(reg_write_e), 32'h2);
    tick();
    check("new RegWriteM", 32'(reg_write_m), 32'h2);
    tick();
    check("new RegWriteW", 32'(reg_write_w), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
